chorus_mixer: RTL and testbench
===============================

Name: chorus_mixer

Overview:
- Wet/dry mixer stage of the chorus DSP chain, running in the 6 MHz DSP clock domain.
- Sits downstream of the delay buffer FSM and upstream of the FTS CDC FIFO.
- Pairs each dry sample with the delayed (wet) sample the delay buffer produces for it, and blends them with a programmable mix weight.
- Emits one rounded, saturated 16-bit sample per audio frame with a single-cycle valid strobe.

Parameters:
PKT_WIDTH, 16, audio sample width (signed two's complement).
MIX_WIDTH, 8, mix weight width; full scale = 2^MIX_WIDTH.
TIMEOUT_CYCLES, 100, clk cycles to wait for a wet sample after a dry sample before bypassing (< 136 clk cycles per 44.1 kHz frame).

Ports:
clk  input  1  DSP clock, 6 MHz
rst_n  input  1  synchronous reset, active-low
pktDry_i  input  PKT_WIDTH  dry sample from STF CDC FIFO
pktDryChanged_i  input  1  one-cycle strobe: new dry sample
pktWet_i  input  PKT_WIDTH  delayed sample from delay buffer
pktWetChanged_i  input  1  one-cycle strobe: new wet sample
mix_i  input  MIX_WIDTH  wet weight m; dry weight = 2^MIX_WIDTH - m
pktMix_o  output  PKT_WIDTH  mixed sample to FTS CDC FIFO
pktMixValid_o  output  1  one-cycle strobe: pktMix_o updated
timeoutErr_o  output  1  sticky: a wet sample never arrived and the dry sample was bypassed
overrunErr_o  output  1  sticky: a dry sample was dropped

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, all outputs 0, timeout counter 0, pending slot empty, latched samples 0.
- Reset asserted mid-operation aborts any in-flight sample; no valid strobe is issued for it.
- States: IDLE, WAIT_WET, MULT, SUM, OUT.
- IDLE:
  - Dry strobe (or pending slot full): latch dry and mix_i (mix is sampled once per frame).
  - Dry and wet strobes in the same cycle: latch both and go to MULT.
  - Dry only: go to WAIT_WET and clear the counter.
  - Wet strobe with no dry latched: ignored.
- WAIT_WET:
  - Wet strobe: latch wet and go to MULT.
  - New dry strobe: replace the latched dry, restart the counter, set overrunErr_o.
  - Counter reaching TIMEOUT_CYCLES-1: set wet := latched dry, set timeoutErr_o, go to MULT. Output therefore equals dry.
  - Wet strobe takes priority over timeout in the same cycle.
- MULT: register pDry = dry * (2^MIX_WIDTH - m) and pWet = wet * m.
  - Signed x unsigned (MIX_WIDTH+1 bits) products, each PKT_WIDTH+MIX_WIDTH+1 bits.
- SUM: s = pDry + pWet + 2^(MIX_WIDTH-1) (round half-up), arithmetic right shift by MIX_WIDTH.
  - Saturate to [-2^(PKT_WIDTH-1), 2^(PKT_WIDTH-1)-1] and register.
- OUT: drive pktMix_o, pulse pktMixValid_o for exactly 1 cycle, return to IDLE.
  - pktMix_o holds its value until the next OUT.
- Latency: pktMixValid_o is high exactly 3 cycles after the cycle the wet sample is latched (wet strobe, or timeout).
- Dry strobe during MULT/SUM/OUT: stored in a one-entry pending slot (value + mix_i) and consumed on return to IDLE.
  - A second dry strobe while the slot is full overwrites it and sets overrunErr_o.
- Wet strobe during MULT/SUM/OUT: ignored.
- Sticky error flags clear only on reset.
- m = 0 gives exact dry passthrough; m = 2^MIX_WIDTH-1 gives near-full wet.

Test Plan:
- Reset: hold rst_n low 4 cycles with strobes toggling -> all outputs 0, no valid pulse. Release -> IDLE.
- Basic mix: dry=1000; wet=3000 5 cycles later; m=64 -> pktMix_o=1500, valid exactly 3 cycles after the wet strobe, 1 cycle wide.
- Cancel and passthrough:
  - dry=1000, wet=-1000, m=128 in the same cycle -> 0.
  - dry=1000, m=0 -> 1000.
- Extremes: dry=wet=32767, m=200 -> 32767; dry=wet=-32768 -> -32768, no wrap.
- Timeout: dry=-500, no wet for 100 cycles -> pktMix_o=-500, timeoutErr_o=1 and stays set. A later wet strobe in IDLE is ignored.
- Overrun/pending:
  - Second dry (=7) in WAIT_WET -> overrunErr_o=1; the following wet pairs with 7.
  - Dry during SUM -> processed after OUT with no loss.

Source files
------------

// File: rtl/chorus_mixer.sv
`default_nettype none
// ============================================================================
// Module      : chorus_mixer
// Description : Wet/dry blend stage of the chorus chain. Pairs each dry sample
//               with its delayed (wet) counterpart, weights them by a
//               per-frame mix value, rounds half-up, saturates and emits one
//               sample per frame with a single-cycle valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module chorus_mixer #(
  parameter int PKT_WIDTH      = 16,
  parameter int MIX_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PKT_WIDTH-1:0] pktDry_i,
  input  logic                 pktDryChanged_i,
  input  logic [PKT_WIDTH-1:0] pktWet_i,
  input  logic                 pktWetChanged_i,
  input  logic [MIX_WIDTH-1:0] mix_i,
  output logic [PKT_WIDTH-1:0] pktMix_o,
  output logic                 pktMixValid_o,
  output logic                 timeoutErr_o,
  output logic                 overrunErr_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_WET = 3'd1;
  localparam logic [2:0] S_MULT     = 3'd2;
  localparam logic [2:0] S_SUM      = 3'd3;
  localparam logic [2:0] S_OUT      = 3'd4;

  localparam int c_PROD_W = PKT_WIDTH + MIX_WIDTH + 1;
  localparam int c_SUM_W  = PKT_WIDTH + MIX_WIDTH + 2;
  localparam int c_CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [c_CNT_W-1:0]          c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [MIX_WIDTH:0]          c_FULL     = {1'b1, {MIX_WIDTH{1'b0}}};
  localparam logic signed [c_SUM_W-1:0]   c_ROUND    = c_SUM_W'(2 ** (MIX_WIDTH - 1));
  localparam logic signed [c_SUM_W-1:0]   c_SAT_MAX  = c_SUM_W'((2 ** (PKT_WIDTH - 1)) - 1);
  localparam logic signed [c_SUM_W-1:0]   c_SAT_MIN  = ~c_SAT_MAX;
  localparam logic [PKT_WIDTH-1:0]        c_OUT_MAX  = {1'b0, {(PKT_WIDTH-1){1'b1}}};
  localparam logic [PKT_WIDTH-1:0]        c_OUT_MIN  = {1'b1, {(PKT_WIDTH-1){1'b0}}};

  logic [2:0]                  r_state;
  logic [2:0]                  w_state_nxt;
  logic [c_CNT_W-1:0]          r_cnt;
  logic [PKT_WIDTH-1:0]        r_dry;
  logic [PKT_WIDTH-1:0]        r_wet;
  logic [MIX_WIDTH-1:0]        r_mix;
  logic                        r_pend_vld;
  logic [PKT_WIDTH-1:0]        r_pend_dry;
  logic [MIX_WIDTH-1:0]        r_pend_mix;
  logic signed [c_PROD_W-1:0]  r_pdry;
  logic signed [c_PROD_W-1:0]  r_pwet;
  logic [PKT_WIDTH-1:0]        r_mix_out;
  logic                        r_timeout_err;
  logic                        r_overrun_err;

  logic                        w_dry_take;
  logic                        w_timeout;
  logic signed [c_PROD_W-1:0]  w_dry_ext;
  logic signed [c_PROD_W-1:0]  w_wet_ext;
  logic signed [c_PROD_W-1:0]  w_wdry;
  logic signed [c_PROD_W-1:0]  w_wwet;
  logic signed [c_SUM_W-1:0]   w_sum;
  logic signed [c_SUM_W-1:0]   w_shift;
  logic [PKT_WIDTH-1:0]        w_sat;
  logic                        w_valid;

  // A dry sample is taken in IDLE either from the strobe or from the pending slot
  assign w_dry_take = pktDryChanged_i | r_pend_vld;
  // Timeout fires only when neither a wet nor a replacement dry arrives
  assign w_timeout  = (r_cnt == c_CNT_LAST) && !pktWetChanged_i && !pktDryChanged_i;

  // Products are formed at full width; weights are non-negative so zero-extend them
  assign w_dry_ext = {{(MIX_WIDTH+1){r_dry[PKT_WIDTH-1]}}, r_dry};
  assign w_wet_ext = {{(MIX_WIDTH+1){r_wet[PKT_WIDTH-1]}}, r_wet};
  assign w_wdry    = {{PKT_WIDTH{1'b0}}, c_FULL - {1'b0, r_mix}};
  assign w_wwet    = {{(PKT_WIDTH+1){1'b0}}, r_mix};

  // Round half-up, then arithmetic shift back to sample scale
  assign w_sum   = {r_pdry[c_PROD_W-1], r_pdry} + {r_pwet[c_PROD_W-1], r_pwet} + c_ROUND;
  assign w_shift = w_sum >>> MIX_WIDTH;

  // Clamp the scaled sum into the signed sample range
  always_comb begin
    w_sat = w_shift[PKT_WIDTH-1:0];
    if (w_shift > c_SAT_MAX) begin
      w_sat = c_OUT_MAX;
    end else if (w_shift < c_SAT_MIN) begin
      w_sat = c_OUT_MIN;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_dry_take) begin
          w_state_nxt = pktWetChanged_i ? S_MULT : S_WAIT_WET;
        end
      end
      S_WAIT_WET: begin
        if (pktWetChanged_i || w_timeout) begin
          w_state_nxt = S_MULT;
        end
      end
      S_MULT:  w_state_nxt = S_SUM;
      S_SUM:   w_state_nxt = S_OUT;
      S_OUT:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: valid strobe for the single OUT cycle
  always_comb begin
    w_valid = 1'b0;
    if (r_state == S_OUT) begin
      w_valid = 1'b1;
    end
  end

  // Sample latching, timeout counter, pending slot, arithmetic pipeline and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_dry         <= '0;
      r_wet         <= '0;
      r_mix         <= '0;
      r_pend_vld    <= 1'b0;
      r_pend_dry    <= '0;
      r_pend_mix    <= '0;
      r_pdry        <= '0;
      r_pwet        <= '0;
      r_mix_out     <= '0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (pktDryChanged_i) begin
            // A fresh strobe supersedes anything still waiting in the slot
            r_dry      <= pktDry_i;
            r_mix      <= mix_i;
            r_pend_vld <= 1'b0;
            if (r_pend_vld) begin
              r_overrun_err <= 1'b1;
            end
          end else if (r_pend_vld) begin
            r_dry      <= r_pend_dry;
            r_mix      <= r_pend_mix;
            r_pend_vld <= 1'b0;
          end
          if (w_dry_take && pktWetChanged_i) begin
            r_wet <= pktWet_i;
          end
        end
        S_WAIT_WET: begin
          if (pktDryChanged_i) begin
            r_dry         <= pktDry_i;
            r_mix         <= mix_i;
            r_cnt         <= '0;
            r_overrun_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
          if (pktWetChanged_i) begin
            r_wet <= pktWet_i;
          end else if (w_timeout) begin
            // Bypass: mixing dry with itself reproduces the dry sample exactly
            r_wet         <= r_dry;
            r_timeout_err <= 1'b1;
          end
        end
        S_MULT: begin
          r_pdry <= w_dry_ext * w_wdry;
          r_pwet <= w_wet_ext * w_wwet;
        end
        S_SUM: begin
          r_mix_out <= w_sat;
        end
        default: begin
        end
      endcase
      // Dry samples arriving while the pipeline is busy park in the one-entry slot
      if ((r_state == S_MULT || r_state == S_SUM || r_state == S_OUT) && pktDryChanged_i) begin
        r_pend_dry <= pktDry_i;
        r_pend_mix <= mix_i;
        r_pend_vld <= 1'b1;
        if (r_pend_vld) begin
          r_overrun_err <= 1'b1;
        end
      end
    end
  end

  assign pktMix_o      = r_mix_out;
  assign pktMixValid_o = w_valid;
  assign timeoutErr_o  = r_timeout_err;
  assign overrunErr_o  = r_overrun_err;

endmodule
`default_nettype wire

// File: tb/tb_chorus_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_chorus_mixer
// Description : Directed self-checking bench for chorus_mixer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chorus_mixer;

  logic        clk;
  logic        rst_n;
  logic [15:0] pktDry_i;
  logic        pktDryChanged_i;
  logic [15:0] pktWet_i;
  logic        pktWetChanged_i;
  logic [7:0]  mix_i;
  logic [15:0] pktMix_o;
  logic        pktMixValid_o;
  logic        timeoutErr_o;
  logic        overrunErr_o;

  int n_run;
  int n_fail;

  chorus_mixer #(
    .PKT_WIDTH      (16),
    .MIX_WIDTH      (8),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pktDry_i        (pktDry_i),
    .pktDryChanged_i (pktDryChanged_i),
    .pktWet_i        (pktWet_i),
    .pktWetChanged_i (pktWetChanged_i),
    .mix_i           (mix_i),
    .pktMix_o        (pktMix_o),
    .pktMixValid_o   (pktMixValid_o),
    .timeoutErr_o    (timeoutErr_o),
    .overrunErr_o    (overrunErr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Dry and wet in the same cycle; expect the result 3 cycles later, 1 cycle wide
  task automatic frame_same(input string tag, input logic [15:0] d, input logic [15:0] w,
                            input logic [7:0] m, input logic [15:0] exp);
    pktDry_i = d; pktWet_i = w; mix_i = m;
    pktDryChanged_i = 1'b1; pktWetChanged_i = 1'b1;
    tick();
    pktDryChanged_i = 1'b0; pktWetChanged_i = 1'b0;
    chk({tag, "_v1"}, {15'd0, pktMixValid_o}, 16'd0);
    tick();
    chk({tag, "_v2"}, {15'd0, pktMixValid_o}, 16'd0);
    tick();
    chk({tag, "_v3"}, {15'd0, pktMixValid_o}, 16'd1);
    chk({tag, "_out"}, pktMix_o, exp);
    tick();
    chk({tag, "_v4"}, {15'd0, pktMixValid_o}, 16'd0);
    chk({tag, "_hold"}, pktMix_o, exp);
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    rst_n = 1'b0;
    pktDry_i = '0; pktWet_i = '0; mix_i = '0;
    pktDryChanged_i = 1'b0; pktWetChanged_i = 1'b0;

    // Reset held 4 cycles with strobes toggling
    for (int i = 0; i < 4; i++) begin
      pktDry_i = 16'd1234; pktWet_i = 16'd4321; mix_i = 8'd77;
      pktDryChanged_i = i[0]; pktWetChanged_i = ~i[0];
      tick();
      chk("rst_valid", {15'd0, pktMixValid_o}, 16'd0);
      chk("rst_mix", pktMix_o, 16'd0);
      chk("rst_terr", {15'd0, timeoutErr_o}, 16'd0);
      chk("rst_oerr", {15'd0, overrunErr_o}, 16'd0);
    end
    pktDryChanged_i = 1'b0; pktWetChanged_i = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", {15'd0, pktMixValid_o}, 16'd0);

    // Basic mix: dry 1000, wet 3000 five cycles later, m=64 -> 1500
    pktDry_i = 16'd1000; mix_i = 8'd64; pktDryChanged_i = 1'b1;
    tick();
    pktDryChanged_i = 1'b0;
    mix_i = 8'd255;  // must not affect this frame
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("basic_wait_valid", {15'd0, pktMixValid_o}, 16'd0);
    end
    pktWet_i = 16'd3000; pktWetChanged_i = 1'b1;
    tick();
    pktWetChanged_i = 1'b0;
    tick();
    chk("basic_v2", {15'd0, pktMixValid_o}, 16'd0);
    tick();
    chk("basic_v3", {15'd0, pktMixValid_o}, 16'd1);
    chk("basic_out", pktMix_o, 16'd1500);
    tick();
    chk("basic_v4", {15'd0, pktMixValid_o}, 16'd0);

    // Cancel, passthrough and extremes
    frame_same("cancel", 16'd1000, -16'sd1000, 8'd128, 16'd0);
    frame_same("pass", 16'd1000, 16'd5555, 8'd0, 16'd1000);
    frame_same("maxpos", 16'd32767, 16'd32767, 8'd200, 16'd32767);
    frame_same("maxneg", 16'h8000, 16'h8000, 8'd200, 16'h8000);
    frame_same("mix1", 16'd2000, 16'd0, 8'd255, 16'd8);
    chk("no_terr", {15'd0, timeoutErr_o}, 16'd0);
    chk("no_oerr", {15'd0, overrunErr_o}, 16'd0);

    // Timeout: dry -500, no wet -> bypass after 100 cycles
    pktDry_i = -16'sd500; mix_i = 8'd100; pktDryChanged_i = 1'b1;
    tick();
    pktDryChanged_i = 1'b0;
    for (int i = 0; i < 99; i++) tick();
    chk("to_terr_early", {15'd0, timeoutErr_o}, 16'd0);
    chk("to_valid_early", {15'd0, pktMixValid_o}, 16'd0);
    tick();
    chk("to_terr_set", {15'd0, timeoutErr_o}, 16'd1);
    tick();
    chk("to_v2", {15'd0, pktMixValid_o}, 16'd0);
    tick();
    chk("to_v3", {15'd0, pktMixValid_o}, 16'd1);
    chk("to_out", pktMix_o, -16'sd500);
    tick();
    // Wet strobe in IDLE with nothing latched is ignored
    pktWet_i = 16'd9999; pktWetChanged_i = 1'b1;
    tick();
    pktWetChanged_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ign_wet_valid", {15'd0, pktMixValid_o}, 16'd0);
    end
    chk("ign_wet_hold", pktMix_o, -16'sd500);
    chk("to_sticky", {15'd0, timeoutErr_o}, 16'd1);

    // Pending: dry during SUM processed after OUT with no loss
    pktDry_i = 16'd200; mix_i = 8'd64; pktDryChanged_i = 1'b1;
    tick();
    pktDryChanged_i = 1'b0;
    pktWet_i = 16'd600; pktWetChanged_i = 1'b1;
    tick();  // MULT
    pktWetChanged_i = 1'b0;
    tick();  // SUM
    pktDry_i = -16'sd300; mix_i = 8'd128; pktDryChanged_i = 1'b1;
    tick();  // OUT
    pktDryChanged_i = 1'b0; mix_i = 8'd0;
    chk("pend_v_a", {15'd0, pktMixValid_o}, 16'd1);
    chk("pend_out_a", pktMix_o, 16'd300);
    tick();  // IDLE consumes slot
    tick();  // WAIT_WET
    pktWet_i = -16'sd100; pktWetChanged_i = 1'b1;
    tick();
    pktWetChanged_i = 1'b0;
    tick();
    tick();
    chk("pend_v_b", {15'd0, pktMixValid_o}, 16'd1);
    chk("pend_out_b", pktMix_o, -16'sd200);
    chk("pend_no_oerr", {15'd0, overrunErr_o}, 16'd0);
    tick();

    // Overrun: second dry in WAIT_WET replaces the first
    pktDry_i = 16'd1000; mix_i = 8'd128; pktDryChanged_i = 1'b1;
    tick();
    pktDryChanged_i = 1'b0;
    tick();
    chk("ovr_before", {15'd0, overrunErr_o}, 16'd0);
    pktDry_i = 16'd7; pktDryChanged_i = 1'b1;
    tick();
    pktDryChanged_i = 1'b0;
    chk("ovr_set", {15'd0, overrunErr_o}, 16'd1);
    pktWet_i = 16'd9; pktWetChanged_i = 1'b1;
    tick();
    pktWetChanged_i = 1'b0;
    tick();
    tick();
    chk("ovr_v3", {15'd0, pktMixValid_o}, 16'd1);
    chk("ovr_out", pktMix_o, 16'd8);
    tick();
    chk("ovr_sticky", {15'd0, overrunErr_o}, 16'd1);

    // Reset mid-operation aborts the in-flight sample
    pktDry_i = 16'd4000; pktWet_i = 16'd4000; mix_i = 8'd10;
    pktDryChanged_i = 1'b1; pktWetChanged_i = 1'b1;
    tick();  // MULT
    pktDryChanged_i = 1'b0; pktWetChanged_i = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mrst_valid", {15'd0, pktMixValid_o}, 16'd0);
    chk("mrst_mix", pktMix_o, 16'd0);
    chk("mrst_terr", {15'd0, timeoutErr_o}, 16'd0);
    chk("mrst_oerr", {15'd0, overrunErr_o}, 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mrst_after_valid", {15'd0, pktMixValid_o}, 16'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
